// File: rtl/ram_sp_ctrl.sv
// Single-port RAM controller: one request at a time, sequenced through a
// small FSM that owns the RAM strobes and the shared tri-state data bus.
module ram_sp_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  // Handshake: a request transfers on a posedge where req_valid && req_ready;
  // the requester holds req_* stable until then.
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] ram_address,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    TURN    = 3'd4
  } state_e;

  state_e                state;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  drive_en;

  assign req_ready = (state == IDLE);
  assign dbg_state = state;

  // Only the WR cycle drives the bus; ram_oe is never high at the same time.
  assign ram_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ram_address <= '0;
      wdata_q     <= '0;
      drive_en    <= 1'b0;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      wr_ack      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      wr_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            ram_address <= req_addr;
            wdata_q     <= req_wdata;
            ram_cs      <= 1'b1;
            if (req_we) begin
              state    <= WR;
              ram_we   <= 1'b1;
              drive_en <= 1'b1;
            end else begin
              state  <= RD_ADDR;
              ram_oe <= 1'b1;
            end
          end
        end
        WR: begin
          state    <= IDLE;
          ram_cs   <= 1'b0;
          ram_we   <= 1'b0;
          drive_en <= 1'b0;
          wr_ack   <= 1'b1;
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          // RAM is driving the bus this cycle; capture and drop the strobes.
          state     <= TURN;
          rsp_rdata <= ram_data;
          rsp_valid <= 1'b1;
          ram_cs    <= 1'b0;
          ram_oe    <= 1'b0;
        end
        TURN: state <= IDLE;
        default: begin
          state    <= IDLE;
          ram_cs   <= 1'b0;
          ram_we   <= 1'b0;
          ram_oe   <= 1'b0;
          drive_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Bench for ram_sp_ctrl: synchronous RAM model on the bus, a timing-level
// reference model checked every cycle, and directed plus random traffic.
module tb_ram_sp_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, wr_ack;
  logic [7:0] rsp_rdata, ram_address;
  wire  [7:0] ram_data;
  logic       ram_cs, ram_we, ram_oe;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  ram_sp_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_ack(wr_ack),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .dbg_state(dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: registers read data at the end of the address cycle,
  // drives the bus the following cycle while oe stays high.
  logic [7:0] ram_mem [256];
  logic [7:0] ram_dout;
  logic       ram_rd_flag;
  assign ram_data = (ram_oe && ram_rd_flag) ? ram_dout : 8'bz;

  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[ram_address] <= ram_data;
    if (ram_cs && ram_oe && !ram_we) ram_dout <= ram_mem[ram_address];
    ram_rd_flag <= ram_cs && ram_oe && !ram_we;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: operation timing derived from the acceptance cycle.
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rdata;
  logic [7:0] rsp_dat_q[$];
  int         rsp_cyc_q[$];
  int         ack_cyc_q[$];
  int         busy_until, acc_cyc;
  logic       acc_valid, acc_we;
  logic [7:0] acc_addr, acc_data;
  int         ack_cnt = 0, rsp_cnt = 0, last_ack_cyc = 0, last_rsp_cyc = 0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    ram_rd_flag = 1'b0;
    ram_dout    = 8'h00;
    busy_until  = 0;
    acc_cyc     = 0;
    acc_valid   = 1'b0;
    acc_we      = 1'b0;
    acc_addr    = 8'h00;
    acc_data    = 8'h00;
    exp_rdata   = 8'h00;
  end

  // Compare process
  always @(negedge clk) begin
    int   k;
    logic exp_ready, exp_cs, exp_we, exp_oe, exp_rsp, exp_ack;
    if (reset) begin
      check("rst_cs", ram_cs, 0);
      check("rst_we", ram_we, 0);
      check("rst_oe", ram_oe, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_wr_ack", wr_ack, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_ram_address", ram_address, 0);
      rsp_cyc_q.delete();
      rsp_dat_q.delete();
      ack_cyc_q.delete();
      busy_until = 0;
      acc_valid  = 1'b0;
      exp_rdata  = 8'h00;
    end else begin
      k = cyc - acc_cyc;
      exp_ready = (cyc >= busy_until);
      check("req_ready", req_ready, exp_ready);
      exp_cs = 1'b0; exp_we = 1'b0; exp_oe = 1'b0;
      if (acc_valid && acc_we && k == 1) begin
        exp_cs = 1'b1; exp_we = 1'b1;
        check("wr_bus", ram_data, acc_data);
      end
      if (acc_valid && !acc_we && (k == 1 || k == 2)) begin
        exp_cs = 1'b1; exp_oe = 1'b1;
      end
      if (acc_valid && !acc_we && k == 2) check("rd_bus", ram_data, acc_data);
      check("ram_cs", ram_cs, exp_cs);
      check("ram_we", ram_we, exp_we);
      check("ram_oe", ram_oe, exp_oe);
      if (ram_oe && ram_we) check("oe_we_overlap", 1, 0);
      if (acc_valid && k >= 1 && k < (acc_we ? 2 : 4)) check("addr_stable", ram_address, acc_addr);

      exp_rsp = (rsp_cyc_q.size() > 0) && (rsp_cyc_q[0] == cyc);
      check("rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp) begin
        exp_rdata = rsp_dat_q.pop_front();
        void'(rsp_cyc_q.pop_front());
      end
      if (rsp_valid) begin rsp_cnt++; last_rsp_cyc = cyc; end
      check("rsp_rdata", rsp_rdata, exp_rdata);

      exp_ack = (ack_cyc_q.size() > 0) && (ack_cyc_q[0] == cyc);
      check("wr_ack", wr_ack, exp_ack);
      if (exp_ack) void'(ack_cyc_q.pop_front());
      if (wr_ack) begin ack_cnt++; last_ack_cyc = cyc; end

      if (req_valid && exp_ready) begin
        acc_valid = 1'b1;
        acc_cyc   = cyc;
        acc_we    = req_we;
        acc_addr  = req_addr;
        if (req_we) begin
          acc_data = req_wdata;
          ref_mem[req_addr] = req_wdata;
          ack_cyc_q.push_back(cyc + 2);
          busy_until = cyc + 2;
        end else begin
          acc_data = ref_mem[req_addr];
          rsp_cyc_q.push_back(cyc + 3);
          rsp_dat_q.push_back(ref_mem[req_addr]);
          busy_until = cyc + 4;
        end
      end
    end
  end

  // Driver tasks: called #1 after a posedge, return #1 after the accept edge.
  task automatic do_req(input logic we, input logic [7:0] a, input logic [7:0] d, output int acc);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    acc = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL req_timeout: got no req_ready expected req_ready within 20 cycles");
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t_wr, t_rd, base;
  int t_bb [4];

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("lit_rst_address", ram_address, 8'h00);
    check("lit_rst_rdata", rsp_rdata, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    check("lit_ready_after_rst", req_ready, 1);
    @(posedge clk); #1;

    // Write 0xA5 to 0x10, read it back
    do_req(1'b1, 8'h10, 8'hA5, t_wr);
    idle(3);
    check("lit_ack_latency", last_ack_cyc - t_wr, 2);
    do_req(1'b0, 8'h10, 8'h00, t_rd);
    idle(5);
    check("lit_rd_latency", last_rsp_cyc - t_rd, 3);
    check("lit_rdata_a5", rsp_rdata, 8'hA5);

    // Back-to-back writes with req_valid held
    base = ack_cnt;
    for (int i = 0; i < 4; i++) do_req(1'b1, 8'(i), 8'(8'h30 + i), t_bb[i]);
    idle(4);
    for (int i = 1; i < 4; i++) check("lit_bb_spacing", t_bb[i] - t_bb[i-1], 2);
    check("lit_bb_acks", ack_cnt - base, 4);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 8'(i), 8'h00, t_rd);
      idle(5);
      check("lit_bb_readback", rsp_rdata, 32'h30 + i);
    end

    // Write then immediate read of the last address
    do_req(1'b1, 8'hFF, 8'h5C, t_wr);
    do_req(1'b0, 8'hFF, 8'h00, t_rd);
    idle(5);
    check("lit_rdata_ff", rsp_rdata, 8'h5C);
    check("lit_wr_rd_gap", t_rd - t_wr, 2);

    // Reset during RD_DATA
    base = rsp_cnt;
    do_req(1'b0, 8'h10, 8'h00, t_rd);
    idle(1);
    reset = 1'b1;
    #1;
    check("lit_abort_cs", ram_cs, 0);
    check("lit_abort_oe", ram_oe, 0);
    check("lit_abort_rsp", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(4);
    check("lit_abort_no_rsp", rsp_cnt - base, 0);
    @(negedge clk);
    check("lit_abort_ready", req_ready, 1);
    @(posedge clk); #1;
    do_req(1'b0, 8'h10, 8'h00, t_rd);
    idle(5);
    check("lit_after_abort", rsp_rdata, 8'hA5);

    // Random read/write mix against the reference model
    for (int i = 0; i < 1000; i++) begin
      do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), t_rd);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
